// File: rtl/mips_lsu_pkg.sv
// Shared definitions for the MIPS load/store unit: access-size codes,
// FSM state encoding and the lane-offset width.
package mips_lsu_pkg;

  // Access size codes as presented on req_size
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Byte-lane offset inside a 32-bit word
  localparam int OFS_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LD_WAIT  = 3'd1,
    ST_RMW_WAIT = 3'd2,
    ST_RMW_WR   = 3'd3,
    ST_RESP     = 3'd4
  } lsu_state_e;

  // Word address of a byte address
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/mips_lsu_lane_unit.sv
// Combinational byte-lane logic for the load/store unit.
// Store side: merges a byte/half into an old word at the given lane, or
// replicates it across all lanes (used for IO writes without read-back).
// Load side: picks the addressed lane and sign- or zero-extends it.
module mips_lsu_lane_unit
  import mips_lsu_pkg::*;
(
  input  logic [31:0]      i_old_word,
  input  logic [31:0]      i_st_data,
  input  logic [1:0]       i_st_size,
  input  logic [OFS_W-1:0] i_st_ofs,
  input  logic             i_st_replicate,
  output logic [31:0]      o_st_word,
  input  logic [31:0]      i_ld_word,
  input  logic [1:0]       i_ld_size,
  input  logic [OFS_W-1:0] i_ld_ofs,
  input  logic             i_ld_signed,
  output logic [31:0]      o_ld_data
);

  logic [7:0]  w_st_byte;
  logic [15:0] w_st_half;
  logic [7:0]  w_ld_byte;
  logic [15:0] w_ld_half;

  assign w_st_byte = i_st_data[7:0];
  assign w_st_half = i_st_data[15:0];
  assign w_ld_byte = i_ld_word[{i_ld_ofs, 3'b000} +: 8];
  assign w_ld_half = i_ld_word[{i_ld_ofs[1], 4'b0000} +: 16];

  // Store word build: merge into old word or replicate across lanes
  always_comb begin
    o_st_word = i_st_data;
    case (i_st_size)
      SZ_BYTE: begin
        if (i_st_replicate) begin
          o_st_word = {4{w_st_byte}};
        end else begin
          o_st_word = i_old_word;
          o_st_word[{i_st_ofs, 3'b000} +: 8] = w_st_byte;
        end
      end
      SZ_HALF: begin
        if (i_st_replicate) begin
          o_st_word = {2{w_st_half}};
        end else if (i_st_ofs[1]) begin
          o_st_word = {w_st_half, i_old_word[15:0]};
        end else begin
          o_st_word = {i_old_word[31:16], w_st_half};
        end
      end
      default: o_st_word = i_st_data;
    endcase
  end

  // Load extract: select lane and extend to 32 bits
  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{i_ld_signed & w_ld_byte[7]}}, w_ld_byte};
      SZ_HALF: o_ld_data = {{16{i_ld_signed & w_ld_half[15]}}, w_ld_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: bridges the MEM stage to a word-wide memory with
// one cycle of synchronous read latency. Sub-word RAM stores use
// read-modify-write; sub-word IO stores replicate data across lanes.
// Build option: LSU_MISALIGN_TRAP_EN reports misaligned half/word accesses
// through resp_err; without it the low address bits are forced to alignment.
//
// Handshake: a request is accepted on a rising edge where i_req_valid and
// o_req_ready are both high; o_req_ready is high only in IDLE and requests
// presented while busy are ignored, not queued. o_resp_valid is a single
// cycle pulse per accepted request, with o_resp_err qualified by it.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter int          IO_BIT      = 31,
  parameter logic [31:0] RESET_RDATA = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_signed,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output lsu_state_e  o_dbg_state
);

  lsu_state_e       r_state;
  lsu_state_e       w_state_nxt;

  logic             r_mem_we;
  logic [31:0]      r_mem_addr;
  logic [31:0]      r_mem_wdata;
  logic             r_resp_valid;
  logic             r_resp_err;
  logic [31:0]      r_resp_rdata;
  logic             r_ld_resp;
  logic [1:0]       r_size;
  logic [OFS_W-1:0] r_ofs;
  logic             r_signed;
  logic [31:0]      r_wdata;
  logic             r_err;

  logic             w_accept;
  logic             w_misalign;
  logic             w_bad;
  logic             w_io;
  logic             w_direct_store;
  logic [31:0]      w_addr_eff;
  logic             w_idle;
  logic [1:0]       w_st_size;
  logic [OFS_W-1:0] w_st_ofs;
  logic [31:0]      w_st_data;
  logic [31:0]      w_st_word;
  logic [31:0]      w_ld_data;

  assign w_idle         = (r_state == ST_IDLE);
  assign o_req_ready    = w_idle;
  assign w_accept       = i_req_valid & w_idle;
  assign w_bad          = w_misalign | (i_req_size == SZ_ILL);
  assign w_io           = i_req_addr[IO_BIT];
  assign w_direct_store = i_req_we & ((i_req_size == SZ_WORD) | w_io);

  // Alignment handling: trap on misalignment, or force the low bits clear
  always_comb begin
    w_addr_eff = i_req_addr;
    w_misalign = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    if (i_req_size == SZ_HALF)      w_misalign = i_req_addr[0];
    else if (i_req_size == SZ_WORD) w_misalign = |i_req_addr[1:0];
`else
    if (i_req_size == SZ_HALF)      w_addr_eff[0]   = 1'b0;
    else if (i_req_size == SZ_WORD) w_addr_eff[1:0] = 2'b00;
`endif
  end

  // In IDLE the lane unit builds direct (word / IO replicated) store data
  // from the live request; afterwards it merges latched data into mem_rdata.
  assign w_st_size = w_idle ? i_req_size : r_size;
  assign w_st_ofs  = w_idle ? w_addr_eff[OFS_W-1:0] : r_ofs;
  assign w_st_data = w_idle ? i_req_wdata : r_wdata;

  mips_lsu_lane_unit u_lane (
    .i_old_word     (i_mem_rdata),
    .i_st_data      (w_st_data),
    .i_st_size      (w_st_size),
    .i_st_ofs       (w_st_ofs),
    .i_st_replicate (w_idle),
    .o_st_word      (w_st_word),
    .i_ld_word      (i_mem_rdata),
    .i_ld_size      (r_size),
    .i_ld_ofs       (r_ofs),
    .i_ld_signed    (r_signed),
    .o_ld_data      (w_ld_data)
  );

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_bad)               w_state_nxt = ST_RESP;
          else if (!i_req_we)      w_state_nxt = ST_LD_WAIT;
          else if (w_direct_store) w_state_nxt = ST_RESP;
          else                     w_state_nxt = ST_RMW_WAIT;
        end
      end
      ST_LD_WAIT:  w_state_nxt = ST_IDLE;
      ST_RMW_WAIT: w_state_nxt = ST_RMW_WR;
      ST_RMW_WR:   w_state_nxt = ST_RESP;
      ST_RESP:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: request latch, registered memory port and response
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= RESET_RDATA;
      r_ld_resp    <= 1'b0;
      r_size       <= SZ_BYTE;
      r_ofs        <= '0;
      r_signed     <= 1'b0;
      r_wdata      <= 32'h0;
      r_err        <= 1'b0;
    end else begin
      r_mem_we     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_ld_resp    <= 1'b0;
      // the load result is presented live in its response cycle, then held
      if (r_ld_resp) r_resp_rdata <= w_ld_data;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_size   <= i_req_size;
            r_ofs    <= w_addr_eff[OFS_W-1:0];
            r_signed <= i_req_signed;
            r_wdata  <= i_req_wdata;
            r_err    <= w_bad;
            if (w_bad) begin
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_mem_addr <= word_align(w_addr_eff);
              if (w_direct_store) begin
                r_mem_we    <= 1'b1;
                r_mem_wdata <= w_st_word;
              end
            end
          end
        end
        ST_LD_WAIT: begin
          r_resp_valid <= 1'b1;
          r_ld_resp    <= 1'b1;
        end
        ST_RMW_WR: begin
          r_mem_we    <= 1'b1;
          r_mem_wdata <= w_st_word;
        end
        ST_RESP: begin
          // error responses were already pulsed at accept
          if (!r_err) r_resp_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_err   = r_resp_err;
  assign o_resp_rdata = r_ld_resp ? w_ld_data : r_resp_rdata;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mips_lsu.sv
// Testbench for mips_lsu: word memory responder with 1-cycle read latency,
// a byte-level reference memory, directed steps and random requests.
module tb_mips_lsu;
  import mips_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  lsu_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  mips_lsu dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_we     (req_we),
    .i_req_size   (req_size),
    .i_req_signed (req_signed),
    .i_req_addr   (req_addr),
    .i_req_wdata  (req_wdata),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_resp_err   (resp_err),
    .o_mem_we     (mem_we),
    .o_mem_addr   (mem_addr),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_dbg_state  (dbg_state)
  );

  // ---------------- memory responder ----------------
  logic [31:0] resp_mem [logic [29:0]];
  logic [31:0] mem_rd_q = 32'h0;
  assign mem_rdata = mem_rd_q;

  always @(posedge clk) begin
    mem_rd_q <= resp_mem.exists(mem_addr[31:2]) ? resp_mem[mem_addr[31:2]] : 32'h0;
    if (mem_we) resp_mem[mem_addr[31:2]] = mem_wdata;
  end

  // ---------------- reference model (byte addressed) ----------------
  logic [7:0]  ref_mem [logic [31:0]];
  logic [31:0] last_load = 32'h0;

  function automatic logic [7:0] rd8(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] wa);
    return {rd8(wa + 32'd3), rd8(wa + 32'd2), rd8(wa + 32'd1), rd8(wa)};
  endfunction

  // ---------------- scoreboard helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // last observed response/write, for literal checks in directed steps
  logic [31:0] obs_rdata;
  logic [31:0] obs_we_data;
  logic        obs_err;

  // ---------------- driver: one request, observed for 5 cycles ----------------
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic        bad;
    logic        misal;
    logic [31:0] eff;
    logic [31:0] wa;
    int          nb;
    int          exp_resp_k;
    int          exp_we_k;
    logic [31:0] exp_rdata;
    logic [31:0] exp_we_data;
    logic [31:0] mask;
    int          we_cnt;
    int          we_k;
    int          resp_cnt;
    int          resp_k;
    logic [31:0] we_addr_s;
    logic [31:0] we_data_s;
    logic [31:0] rdata_s;
    logic        err_s;

    // model of the request
    nb    = (sz == SZ_BYTE) ? 1 : (sz == SZ_HALF) ? 2 : 4;
    misal = ((sz == SZ_HALF) && addr[0]) || ((sz == SZ_WORD) && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    bad = misal || (sz == SZ_ILL);
    eff = addr;
`else
    bad = (sz == SZ_ILL);
    eff = (sz == SZ_HALF) ? (addr & ~32'd1) : (sz == SZ_WORD) ? (addr & ~32'd3) : addr;
`endif
    wa          = eff & ~32'd3;
    exp_we_k    = 0;
    exp_rdata   = 32'h0;
    exp_we_data = 32'h0;
    if (bad) begin
      exp_resp_k = 1;
    end else if (!we) begin
      for (int i = 0; i < nb; i++) exp_rdata |= 32'(rd8(eff + 32'(i))) << (8 * i);
      if (nb < 4) begin
        mask = (32'd1 << (8 * nb)) - 32'd1;
        if (sgn && exp_rdata[8 * nb - 1]) exp_rdata |= ~mask;
      end
      last_load  = exp_rdata;
      exp_resp_k = 2;
    end else begin
      if (nb == 4) begin
        for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = 8'(wdata >> (8 * i));
        exp_we_k = 1;
      end else if (addr[31]) begin
        for (int i = 0; i < 4; i++) ref_mem[wa + 32'(i)] = 8'(wdata >> (8 * (i % nb)));
        exp_we_k = 1;
      end else begin
        for (int i = 0; i < nb; i++) ref_mem[eff + 32'(i)] = 8'(wdata >> (8 * i));
        exp_we_k = 3;
      end
      exp_we_data = ref_word(wa);
      exp_resp_k  = exp_we_k + 1;
    end

    // drive
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;

    // observe
    we_cnt = 0; we_k = 0; resp_cnt = 0; resp_k = 0;
    we_addr_s = 32'h0; we_data_s = 32'h0; rdata_s = 32'h0; err_s = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        chk("busy_ready", {31'b0, req_ready}, 32'd0);
        if (!bad) chk("mem_addr_issue", mem_addr, wa);
      end
      if (mem_we) begin
        we_cnt++; we_k = k; we_addr_s = mem_addr; we_data_s = mem_wdata;
      end
      if (resp_valid) begin
        resp_cnt++; resp_k = k; rdata_s = resp_rdata; err_s = resp_err;
      end
    end

    chk("resp_count", 32'(resp_cnt), 32'd1);
    chk("resp_cycle", 32'(resp_k), 32'(exp_resp_k));
    chk("resp_err", {31'b0, err_s}, {31'b0, bad});
    if (!bad && !we) chk("load_data", rdata_s, exp_rdata);
    chk("we_count", 32'(we_cnt), (exp_we_k != 0) ? 32'd1 : 32'd0);
    if (exp_we_k != 0) begin
      chk("we_cycle", 32'(we_k), 32'(exp_we_k));
      chk("we_addr", we_addr_s, wa);
      chk("we_data", we_data_s, exp_we_data);
    end
    chk("rdata_hold", resp_rdata, last_load);
    obs_rdata   = rdata_s;
    obs_we_data = we_data_s;
    obs_err     = err_s;
  endtask

  // ---------------- reset taken in RMW_WAIT ----------------
  task automatic do_reset_mid_rmw(input logic [31:0] addr, input logic [31:0] wdata);
    int bad_cnt;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rmw_wait_state", {29'b0, dbg_state}, {29'b0, ST_RMW_WAIT});
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_mid_resp", {31'b0, resp_valid}, 32'd0);
    chk("rst_mid_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mid_addr", mem_addr, 32'h0);
    chk("rst_mid_rdata", resp_rdata, 32'h0);
    last_load = 32'h0;
    rst_n     = 1'b1;
    bad_cnt   = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (mem_we || resp_valid) bad_cnt++;
    end
    chk("rst_mid_quiet", 32'(bad_cnt), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_size   = SZ_BYTE;
    req_signed = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    // word store then load
    do_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'hDEADBEEF);
    chk("sw_lit", obs_we_data, 32'hDEADBEEF);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
    chk("lw_lit", obs_rdata, 32'hDEADBEEF);

    // extension cases
    do_req(1'b1, SZ_WORD, 1'b0, 32'h104, 32'h00008000);
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h105, 32'h0);
    chk("lb_lit", obs_rdata, 32'hFFFFFF80);
    do_req(1'b0, SZ_BYTE, 1'b0, 32'h105, 32'h0);
    chk("lbu_lit", obs_rdata, 32'h00000080);
    do_req(1'b0, SZ_HALF, 1'b1, 32'h104, 32'h0);
    chk("lh_lit", obs_rdata, 32'hFFFF8000);

    // sub-word RAM store (read-modify-write)
    do_req(1'b1, SZ_WORD, 1'b0, 32'h100, 32'h11223344);
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h102, 32'h000000AA);
    chk("sb_rmw_lit", obs_we_data, 32'h11AA3344);

    // sub-word IO store (replicated)
    do_req(1'b1, SZ_HALF, 1'b0, 32'h80000008, 32'h00001234);
    chk("sh_io_lit", obs_we_data, 32'h12341234);

    // misaligned word load
    do_req(1'b0, SZ_WORD, 1'b0, 32'h103, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_err", {31'b0, obs_err}, 32'd1);
`else
    chk("lw_mis_data", obs_rdata, 32'h11AA3344);
`endif

    // illegal size
    do_req(1'b1, SZ_ILL, 1'b0, 32'h108, 32'h55555555);

    // reset while waiting on the RMW read; the store must be dropped
    do_reset_mid_rmw(32'h101, 32'h000000EE);
    do_req(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
    chk("rmw_dropped", obs_rdata, 32'h11AA3344);

    // random traffic over a small RAM and IO window
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : 32'h00000100;
      a = a + 32'($urandom_range(0, 31));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
